// File: rtl/ups_seq_pkg.sv
// Shared definitions for the UPS output sequencer: FSM states, CTRL bit
// positions, register indices and status word bit positions.
package ups_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } seq_state_t;

    // CTRL register bits
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;
    localparam int CTRL_TRIG  = 3;

    // Register indices inside the bank
    localparam int REG_CTRL  = 0;
    localparam int REG_NSTEP = 1;
    localparam int REG_LOOPS = 2;
    localparam int REG_IDLE  = 3;

    // Status word bit positions
    localparam int ST_ACTIVE   = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_ABORT    = 2;
    localparam int ST_WAIT     = 3;
    localparam int ST_IDX_LSB  = 4;
    localparam int ST_PASS_LSB = 8;
    localparam int ST_ERR      = 24;

    // A zero duration still shows the pattern for one cycle
    function automatic logic [23:0] dur_clamp(input logic [23:0] d);
        return (d == 24'd0) ? 24'd1 : d;
    endfunction

endpackage

// File: rtl/ups_seq_trig_sync.sv
// External trigger conditioning: two-flop synchroniser followed by a
// rising-edge detector. Only compiled when UPS_SEQ_TRIG_EN is defined.
`ifdef UPS_SEQ_TRIG_EN
module ups_seq_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_in,
    output logic trig_rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Synchronise the pin and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= trig_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign trig_rise = sync2_reg & ~prev_reg;

endmodule
`endif

// File: rtl/ups_seq_ctrl.sv
// Register-driven output sequencer. Plays a table of (pattern, duration)
// steps from the register bank on seq_out for N passes or continuously and
// reports progress through a registered status word.
// Optional external trigger support: define UPS_SEQ_TRIG_EN.
module ups_seq_ctrl
    import ups_seq_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DI    = 4,
    parameter int OW    = 8,
    parameter int STEP0 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0][31:0]  cfg_data,
    input  logic [DW-1:0]        cfg_dv,
`ifdef UPS_SEQ_TRIG_EN
    input  logic                 trig_in,
`endif
    output logic [OW-1:0]        seq_out,
    output logic                 seq_active,
    output logic                 seq_step,
    output logic                 seq_done,
    output logic [31:0]          seq_status
);

    localparam int NS = DW - STEP0;

    seq_state_t    state_reg;
    logic [DI-1:0] idx_reg;
    logic [23:0]   timer_reg;
    logic [15:0]   pass_reg;
    logic [DI-1:0] nsteps_reg;
    logic [15:0]   loops_reg;
    logic          forever_reg;
    logic          trig_mode_reg;
    logic          done_reg;
    logic          abort_reg;
    logic          err_reg;
    logic [31:0]   status_next;

    logic          trig_rise;

`ifdef UPS_SEQ_TRIG_EN
    localparam logic TRIG_EN = 1'b1;

    ups_seq_trig_sync u_trig_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .trig_rise (trig_rise)
    );
`else
    localparam logic TRIG_EN = 1'b0;
    assign trig_rise = 1'b0;
`endif

    // Step table is read live from the bank at each load
    logic [OW-1:0] step_pat [NS];
    logic [23:0]   step_dur [NS];

    for (genvar gi = 0; gi < NS; gi++) begin : g_step
        assign step_pat[gi] = cfg_data[STEP0+gi][OW-1:0];
        assign step_dur[gi] = dur_clamp(cfg_data[STEP0+gi][31:8]);
    end

    logic          ctrl_wr;
    logic          cmd_start;
    logic          cmd_stop;
    logic          want_trig;
    logic [OW-1:0] idle_val;
    logic [DI-1:0] cfg_nsteps;
    logic [15:0]   cfg_loops;
    logic          cfg_bad;
    logic [DI-1:0] idx_inc;
    logic          last_step;
    logic [15:0]   pass_inc;
    logic          more_passes;
    logic          unused_cfg;

    // Stop dominates start when both arrive in the same CTRL write
    assign ctrl_wr     = cfg_dv[REG_CTRL];
    assign cmd_start   = ctrl_wr & cfg_data[REG_CTRL][CTRL_START] & ~cfg_data[REG_CTRL][CTRL_STOP];
    assign cmd_stop    = ctrl_wr & cfg_data[REG_CTRL][CTRL_STOP];
    assign want_trig   = cfg_data[REG_CTRL][CTRL_TRIG] & TRIG_EN;
    assign idle_val    = cfg_data[REG_IDLE][OW-1:0];
    assign cfg_nsteps  = cfg_data[REG_NSTEP][DI-1:0];
    assign cfg_loops   = (cfg_data[REG_LOOPS][15:0] == 16'd0) ? 16'd1 : cfg_data[REG_LOOPS][15:0];
    assign cfg_bad     = (cfg_nsteps == '0) || (int'(cfg_nsteps) > NS);
    assign idx_inc     = idx_reg + DI'(1);
    assign last_step   = (idx_reg == nsteps_reg - DI'(1));
    assign pass_inc    = (pass_reg == 16'hFFFF) ? pass_reg : pass_reg + 16'd1;
    assign more_passes = forever_reg || (pass_inc < loops_reg);
    assign unused_cfg  = ^{cfg_data, cfg_dv};

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            timer_reg     <= '0;
            pass_reg      <= '0;
            nsteps_reg    <= '0;
            loops_reg     <= '0;
            forever_reg   <= 1'b0;
            trig_mode_reg <= 1'b0;
            done_reg      <= 1'b0;
            abort_reg     <= 1'b0;
            err_reg       <= 1'b0;
            seq_out       <= '0;
            seq_active    <= 1'b0;
            seq_step      <= 1'b0;
            seq_done      <= 1'b0;
        end else begin
            seq_step <= 1'b0;
            seq_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    seq_out <= idle_val;
                    if (cmd_start) begin
                        if (cfg_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            nsteps_reg    <= cfg_nsteps;
                            loops_reg     <= cfg_loops;
                            forever_reg   <= cfg_data[REG_CTRL][CTRL_LOOP];
                            trig_mode_reg <= want_trig;
                            done_reg      <= 1'b0;
                            abort_reg     <= 1'b0;
                            err_reg       <= 1'b0;
                            pass_reg      <= '0;
                            idx_reg       <= '0;
                            seq_active    <= 1'b1;
                            if (want_trig) begin
                                state_reg <= S_WAIT_TRIG;
                            end else begin
                                state_reg <= S_RUN;
                                seq_out   <= step_pat[0];
                                timer_reg <= step_dur[0];
                                seq_step  <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (cmd_stop) begin
                        state_reg  <= S_IDLE;
                        seq_out    <= idle_val;
                        seq_active <= 1'b0;
                        abort_reg  <= 1'b1;
                    end else if (trig_rise) begin
                        state_reg <= S_RUN;
                        idx_reg   <= '0;
                        seq_out   <= step_pat[0];
                        timer_reg <= step_dur[0];
                        seq_step  <= 1'b1;
                    end else begin
                        seq_out <= idle_val;
                    end
                end
                S_RUN: begin
                    if (cmd_stop) begin
                        state_reg  <= S_IDLE;
                        seq_out    <= idle_val;
                        seq_active <= 1'b0;
                        abort_reg  <= 1'b1;
                    end else if (timer_reg == 24'd1) begin
                        if (!last_step) begin
                            idx_reg   <= idx_inc;
                            seq_out   <= step_pat[idx_inc];
                            timer_reg <= step_dur[idx_inc];
                            seq_step  <= 1'b1;
                        end else begin
                            pass_reg <= pass_inc;
                            if (more_passes) begin
                                idx_reg <= '0;
                                if (trig_mode_reg) begin
                                    state_reg <= S_WAIT_TRIG;
                                    seq_out   <= idle_val;
                                end else begin
                                    seq_out   <= step_pat[0];
                                    timer_reg <= step_dur[0];
                                    seq_step  <= 1'b1;
                                end
                            end else begin
                                state_reg  <= S_DONE;
                                seq_out    <= idle_val;
                                seq_done   <= 1'b1;
                                seq_active <= 1'b0;
                                done_reg   <= 1'b1;
                            end
                        end
                    end else begin
                        timer_reg <= timer_reg - 24'd1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    seq_out   <= idle_val;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Assemble the status word from the current sequencer state
    always_comb begin
        status_next                          = '0;
        status_next[ST_ACTIVE]               = (state_reg == S_RUN) || (state_reg == S_WAIT_TRIG);
        status_next[ST_DONE]                 = done_reg;
        status_next[ST_ABORT]                = abort_reg;
        status_next[ST_WAIT]                 = (state_reg == S_WAIT_TRIG);
        status_next[ST_IDX_LSB +: DI]        = idx_reg;
        status_next[ST_PASS_LSB +: 16]       = pass_reg;
        status_next[ST_ERR]                  = err_reg;
    end

    // Register the status word for bank read-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_status <= '0;
        end else begin
            seq_status <= status_next;
        end
    end

endmodule

// File: tb/tb_ups_seq_ctrl.sv
// Self-checking bench for ups_seq_ctrl: a reference model expands the step
// table into per-cycle expected outputs, a monitor compares them whenever
// the sequencer presents output.
module tb_ups_seq_ctrl;

    localparam int DW    = 16;
    localparam int DI    = 4;
    localparam int OW    = 8;
    localparam int STEP0 = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DW-1:0][31:0] cfg_data;
    logic [DW-1:0]       cfg_dv;
`ifdef UPS_SEQ_TRIG_EN
    logic                trig_in = 1'b0;
`endif
    logic [OW-1:0]       seq_out;
    logic                seq_active;
    logic                seq_step;
    logic                seq_done;
    logic [31:0]         seq_status;

    always #5 clk = ~clk;

    ups_seq_ctrl #(.DW(DW), .DI(DI), .OW(OW), .STEP0(STEP0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_data   (cfg_data),
        .cfg_dv     (cfg_dv),
`ifdef UPS_SEQ_TRIG_EN
        .trig_in    (trig_in),
`endif
        .seq_out    (seq_out),
        .seq_active (seq_active),
        .seq_step   (seq_step),
        .seq_done   (seq_done),
        .seq_status (seq_status)
    );

    typedef struct packed {
        logic [7:0] out;
        logic       step;
        logic       done;
        logic       active;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pat[12];
    int   m_dur[12];
    int   m_idle = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every cycle the sequencer shows output, pop and compare
    always @(negedge clk) begin
        exp_t e;
        if (seq_active || seq_done || seq_step) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output out=%h step=%b done=%b active=%b required=no output",
                         seq_out, seq_step, seq_done, seq_active);
            end else begin
                e = exp_q.pop_front();
                if ({seq_out, seq_step, seq_done, seq_active} !== e) begin
                    errors++;
                    $display("FAIL seq_cycle actual out=%h step=%b done=%b active=%b required out=%h step=%b done=%b active=%b",
                             seq_out, seq_step, seq_done, seq_active, e.out, e.step, e.done, e.active);
                end
            end
        end
    end

    // Reference model: each step shows its pattern max(D,1) cycles, passes back to back
    function automatic void push_cycles(int n, int passes, int maxc);
        int c = 0;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                int d = (m_dur[k] == 0) ? 1 : m_dur[k];
                for (int t = 0; t < d; t++) begin
                    if (c >= maxc) return;
                    exp_q.push_back('{out: 8'(m_pat[k]), step: (t == 0), done: 1'b0, active: 1'b1});
                    c++;
                end
            end
        end
    endfunction

    function automatic void push_done();
        exp_q.push_back('{out: 8'(m_idle), step: 1'b0, done: 1'b1, active: 1'b0});
    endfunction

    function automatic void push_wait(int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{out: 8'(m_idle), step: 1'b0, done: 1'b0, active: 1'b1});
    endfunction

    function automatic logic [31:0] st_exp(bit act, bit dn, bit ab, bit wt, int pass, bit err);
        logic [31:0] s;
        s      = '0;
        s[0]   = act;
        s[1]   = dn;
        s[2]   = ab;
        s[3]   = wt;
        s[23:8] = pass[15:0];
        s[24]  = err;
        return s;
    endfunction

    // Register write: value is live, write pulse lasts one cycle
    task automatic wr(int idx, logic [31:0] val);
        cfg_data[idx] = val;
        cfg_dv[idx]   = 1'b1;
        @(posedge clk);
        #1;
        cfg_dv[idx]   = 1'b0;
    endtask

    task automatic tick(int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_step(int k, int d, int p);
        m_pat[k] = p;
        m_dur[k] = d;
        wr(STEP0 + k, {d[23:0], p[7:0]});
    endtask

    task automatic set_cfg(int n, int loops, int idle);
        wr(1, n);
        wr(2, loops);
        wr(3, idle);
        m_idle = idle;
    endtask

    task automatic wait_idle(int budget, string name);
        int n = 0;
        while ((exp_q.size() != 0 || seq_active || seq_done) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout actual=still running (%0d expected cycles left) required=idle", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    localparam logic [31:0] ST_MASK = 32'hFFFF_FF0F;

    initial begin
        int n, lp, idle, bn;
        bit bad;

        cfg_data = '0;
        cfg_dv   = '0;
        tick(3);
        check("reset_out", seq_out, 0);
        check("reset_active", seq_active, 0);
        check("reset_step", seq_step, 0);
        check("reset_done", seq_done, 0);
        check("reset_status", seq_status, 0);
        rst_n = 1'b1;
        tick(1);

        // Basic three-step table, two passes
        set_step(0, 2, 8'hA1);
        set_step(1, 1, 8'hB2);
        set_step(2, 3, 8'hC3);
        set_cfg(3, 2, 8'h0F);
        tick(1);
        check("idle_val_out", seq_out, 8'h0F);
        push_cycles(3, 2, 1000);
        push_done();
        wr(0, 32'h1);
        wait_idle(100, "basic");
        tick(2);
        check("basic_status", seq_status & ST_MASK, st_exp(0, 1, 0, 0, 2, 0));

        // Invalid step count sets the error flag and does not start
        wr(1, 0);
        wr(0, 32'h1);
        tick(2);
        check("err_active", seq_active, 0);
        check("err_flag", seq_status[24], 1);

        // Next valid start clears the error
        wr(1, 3);
        wr(2, 1);
        push_cycles(3, 1, 1000);
        push_done();
        wr(0, 32'h1);
        wait_idle(100, "recover");
        tick(2);
        check("recover_status", seq_status & ST_MASK, st_exp(0, 1, 0, 0, 1, 0));

        // Continuous run stopped after 7 cycles
        wr(1, 2);
        push_cycles(2, 100, 7);
        wr(0, 32'h5);
        tick(6);
        wr(0, 32'h2);
        check("stop_out", seq_out, m_idle);
        check("stop_active", seq_active, 0);
        wait_idle(20, "stop");
        tick(2);
        check("stop_status", seq_status & ST_MASK, st_exp(0, 0, 1, 0, 7 / 3, 0));

        // Start and stop together in idle: nothing happens
        wr(0, 32'h3);
        tick(3);
        check("startstop_idle", seq_active, 0);

        // Restart during run ignored; live rewrite of step 1 shows in pass 2
        wr(1, 3);
        wr(2, 2);
        push_cycles(3, 1, 1000);
        m_pat[1] = 8'h55;
        push_cycles(3, 1, 1000);
        push_done();
        wr(0, 32'h1);
        tick(1);
        wr(0, 32'h1);
        tick(1);
        cfg_data[STEP0+1][7:0] = 8'h55;
        wait_idle(100, "rewrite");

        // Zero durations hold one cycle each
        set_step(0, 0, 8'h11);
        set_step(1, 0, 8'h22);
        set_cfg(2, 1, 8'h3C);
        push_cycles(2, 1, 1000);
        push_done();
        wr(0, 32'h1);
        wait_idle(50, "zero_dur");

        // Reset in the middle of a run
        set_step(0, 2, 8'hA1);
        set_step(1, 1, 8'hB2);
        set_step(2, 3, 8'hC3);
        set_cfg(3, 2, 8'h0F);
        push_cycles(3, 2, 4);
        wr(0, 32'h1);
        tick(3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_run_out", seq_out, 0);
        check("rst_run_active", seq_active, 0);
        check("rst_run_step", seq_step, 0);
        check("rst_run_done", seq_done, 0);
        check("rst_run_status", seq_status, 0);
        rst_n = 1'b1;
        tick(2);
        check("rst_run_drain", exp_q.size(), 0);

`ifdef UPS_SEQ_TRIG_EN
        // Triggered passes: wait, run on trigger edge, wait again
        set_step(0, 2, 8'h5A);
        set_cfg(1, 2, 8'h0F);
        push_wait(5);
        push_cycles(1, 1, 1000);
        push_wait(4);
        push_cycles(1, 1, 1000);
        push_done();
        wr(0, 32'h9);
        tick(2);
        check("trig_wait_status", seq_status[3], 1);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(5);
        trig_in = 1'b1;
        tick(6);
        trig_in = 1'b0;
        wait_idle(50, "trig");
        tick(2);
        check("trig_status", seq_status & ST_MASK, st_exp(0, 1, 0, 0, 2, 0));
`endif

        // Randomised tables and loop counts
        for (int it = 0; it < 24; it++) begin
            n    = $urandom_range(1, 4);
            lp   = $urandom_range(0, 3);
            idle = $urandom_range(0, 255);
            bad  = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < n; k++)
                set_step(k, $urandom_range(0, 3), $urandom_range(0, 255));
            if (bad) begin
                bn = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 15);
                set_cfg(bn, lp, idle);
                wr(0, 32'h1);
                tick(2);
                check("rand_bad_active", seq_active, 0);
                check("rand_bad_err", seq_status[24], 1);
            end else begin
                set_cfg(n, lp, idle);
                push_cycles(n, (lp == 0) ? 1 : lp, 100000);
                push_done();
                wr(0, 32'h1);
                wait_idle(200, "rand");
                tick(2);
                check("rand_status", seq_status & ST_MASK, st_exp(0, 1, 0, 0, (lp == 0) ? 1 : lp, 0));
                check("rand_idle_out", seq_out, idle);
            end
        end

        tick(2);
        check("final_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
